// File: rtl/addr_reg_unit.sv
// Address register with increment/decrement/shift/load commands, a small LIFO
// shadow stack for saving and restoring the register, and sticky stack error flag.
module addr_reg_unit #(
  parameter int unsigned       WIDTH     = 12,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             REST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             CLR,
  input  logic             POP,
  input  logic             LOAD,
  input  logic             INR,
  input  logic             DCR,
  input  logic             SHL,
  input  logic             SHR,
  input  logic             SIN,
  input  logic             PUSH,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CW-1:0]    COUNT,
  output logic             ERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full, empty;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Only meaningful when the stack is non-empty.
  assign top_idx = AW'(cnt_q - CW'(1));
  assign top     = mem[top_idx];

  // Next-state: prioritised Q command plus stack push/pop/exchange handling.
  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    mem_wa  = AW'(cnt_q);

    if (CLR) begin
      q_d     = '0;
      carry_d = 1'b0;
    end else if (POP) begin
      if (empty) begin
        err_d = 1'b1;
      end else if (PUSH) begin
        // Exchange register with the top entry; occupancy unchanged.
        q_d     = top;
        carry_d = 1'b0;
        mem_we  = 1'b1;
        mem_wa  = top_idx;
      end else begin
        q_d     = top;
        carry_d = 1'b0;
        cnt_d   = cnt_q - CW'(1);
      end
    end else if (LOAD) begin
      q_d     = DATA_IN;
      carry_d = 1'b0;
    end else if (INR) begin
      q_d     = q_q + WIDTH'(1);
      carry_d = &q_q;
    end else if (DCR) begin
      q_d     = q_q - WIDTH'(1);
      carry_d = (q_q == '0);
    end else if (SHL) begin
      q_d     = {q_q[WIDTH-2:0], SIN};
      carry_d = q_q[WIDTH-1];
    end else if (SHR) begin
      q_d     = {SIN, q_q[WIDTH-1:1]};
      carry_d = q_q[0];
    end

    // Plain push whenever POP did not win (CLR suppresses POP but not PUSH).
    if (PUSH && !(POP && !CLR)) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        mem_wa = AW'(cnt_q);
        cnt_d  = cnt_q + CW'(1);
      end
    end

    // CLR dominates any error raised in the same cycle.
    if (CLR) begin
      err_d = 1'b0;
    end
  end

  // Register state with asynchronous reset; stack storage is left untouched.
  always_ff @(posedge clk or posedge REST) begin
    if (REST) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stack storage write port; writes blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !REST) begin
      mem[mem_wa] <= q_q;
    end
  end

  assign DATA_OUT = q_q;
  assign CARRY    = carry_q;
  assign ZERO     = (q_q == '0);
  assign FULL     = full;
  assign EMPTY    = empty;
  assign COUNT    = cnt_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_addr_reg_unit.sv
// Directed self-checking bench for addr_reg_unit (WIDTH=12, DEPTH=4, RESET_VAL=0).
module tb_addr_reg_unit;

  logic        clk = 1'b0;
  logic        REST;
  logic [11:0] DATA_IN;
  logic        CLR, POP, LOAD, INR, DCR, SHL, SHR, SIN, PUSH;
  logic [11:0] DATA_OUT;
  logic        CARRY, ZERO, FULL, EMPTY, ERR;
  logic [2:0]  COUNT;

  int n_checks = 0;
  int n_errors = 0;

  addr_reg_unit #(
    .WIDTH    (12),
    .DEPTH    (4),
    .RESET_VAL(12'h000)
  ) dut (
    .clk     (clk),
    .REST    (REST),
    .DATA_IN (DATA_IN),
    .CLR     (CLR),
    .POP     (POP),
    .LOAD    (LOAD),
    .INR     (INR),
    .DCR     (DCR),
    .SHL     (SHL),
    .SHR     (SHR),
    .SIN     (SIN),
    .PUSH    (PUSH),
    .DATA_OUT(DATA_OUT),
    .CARRY   (CARRY),
    .ZERO    (ZERO),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .ERR     (ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cmds();
    CLR = 0; POP = 0; LOAD = 0; INR = 0; DCR = 0; SHL = 0; SHR = 0; SIN = 0; PUSH = 0;
    DATA_IN = 12'h000;
  endtask

  // Apply the currently driven commands across one rising edge, then clear them.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_cmds();
  endtask

  task automatic load(input logic [11:0] v);
    LOAD = 1; DATA_IN = v;
    tick();
  endtask

  initial begin
    idle_cmds();
    REST = 1;
    #2;
    check("rst_q",     32'(DATA_OUT), 32'h000);
    check("rst_count", 32'(COUNT),    32'd0);
    check("rst_empty", 32'(EMPTY),    32'd1);
    check("rst_zero",  32'(ZERO),     32'd1);
    check("rst_err",   32'(ERR),      32'd0);
    check("rst_carry", 32'(CARRY),    32'd0);
    check("rst_full",  32'(FULL),     32'd0);

    // Commands ignored while reset held.
    LOAD = 1; DATA_IN = 12'h5A5; PUSH = 1;
    tick();
    check("rst_ign_q",   32'(DATA_OUT), 32'h000);
    check("rst_ign_cnt", 32'(COUNT),    32'd0);
    REST = 0;

    // Increment overflow and decrement borrow.
    load(12'hFFF);
    check("load_q", 32'(DATA_OUT), 32'hFFF);
    check("load_c", 32'(CARRY),    32'd0);
    INR = 1; tick();
    check("inr_wrap_q", 32'(DATA_OUT), 32'h000);
    check("inr_wrap_c", 32'(CARRY),    32'd1);
    check("inr_wrap_z", 32'(ZERO),     32'd1);
    DCR = 1; tick();
    check("dcr_brw_q", 32'(DATA_OUT), 32'hFFF);
    check("dcr_brw_c", 32'(CARRY),    32'd1);
    DCR = 1; tick();
    check("dcr_q", 32'(DATA_OUT), 32'hFFE);
    check("dcr_c", 32'(CARRY),    32'd0);

    // Shifts.
    load(12'h801);
    SHL = 1; SIN = 1; tick();
    check("shl_q", 32'(DATA_OUT), 32'h003);
    check("shl_c", 32'(CARRY),    32'd1);
    SHR = 1; SIN = 0; tick();
    check("shr_q", 32'(DATA_OUT), 32'h001);
    check("shr_c", 32'(CARRY),    32'd1);
    tick();
    check("hold_q", 32'(DATA_OUT), 32'h001);
    check("hold_c", 32'(CARRY),    32'd1);

    // Priority: LOAD beats INR/SHL.
    LOAD = 1; INR = 1; SHL = 1; DATA_IN = 12'h100; tick();
    check("prio_q", 32'(DATA_OUT), 32'h100);
    check("prio_c", 32'(CARRY),    32'd0);

    // Fill the stack, overflow, then drain and underflow.
    for (int i = 1; i <= 4; i++) begin
      load(12'(i * 12'h111));
      PUSH = 1; tick();
    end
    check("full_f",   32'(FULL),  32'd1);
    check("full_cnt", 32'(COUNT), 32'd4);
    check("full_err", 32'(ERR),   32'd0);
    PUSH = 1; tick();
    check("ovf_err", 32'(ERR),   32'd1);
    check("ovf_cnt", 32'(COUNT), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      POP = 1; tick();
      check("pop_q", 32'(DATA_OUT), 32'(i * 12'h111));
    end
    check("pop_empty", 32'(EMPTY), 32'd1);
    check("pop_err",   32'(ERR),   32'd1);
    POP = 1; LOAD = 1; DATA_IN = 12'h007; tick();
    check("unf_q",   32'(DATA_OUT), 32'h111);
    check("unf_err", 32'(ERR),      32'd1);
    check("unf_cnt", 32'(COUNT),    32'd0);
    CLR = 1; tick();
    check("clr_q",   32'(DATA_OUT), 32'h000);
    check("clr_err", 32'(ERR),      32'd0);

    // Exchange, then CLR suppressing POP.
    load(12'h0AA);
    PUSH = 1; tick();
    load(12'h555);
    PUSH = 1; POP = 1; tick();
    check("xchg_q",   32'(DATA_OUT), 32'h0AA);
    check("xchg_cnt", 32'(COUNT),    32'd1);
    CLR = 1; POP = 1; LOAD = 1; DATA_IN = 12'h003; tick();
    check("clrpop_q",   32'(DATA_OUT), 32'h000);
    check("clrpop_cnt", 32'(COUNT),    32'd1);
    check("clrpop_err", 32'(ERR),      32'd0);
    POP = 1; tick();
    check("xchg_top", 32'(DATA_OUT), 32'h555);

    // PUSH concurrent with INR.
    load(12'h010);
    PUSH = 1; INR = 1; tick();
    check("pinr_q",   32'(DATA_OUT), 32'h011);
    check("pinr_cnt", 32'(COUNT),    32'd1);
    POP = 1; tick();
    check("pinr_top", 32'(DATA_OUT), 32'h010);

    // CLR with PUSH pushes pre-edge Q.
    load(12'h321);
    CLR = 1; PUSH = 1; tick();
    check("clrpush_q", 32'(DATA_OUT), 32'h000);
    POP = 1; tick();
    check("clrpush_top", 32'(DATA_OUT), 32'h321);

    // Asynchronous reset mid-cycle discards stack.
    load(12'hABC);
    PUSH = 1; tick();
    PUSH = 1; tick();
    check("pre_rst_cnt", 32'(COUNT), 32'd2);
    #1;
    REST = 1;
    #1;
    check("arst_q",     32'(DATA_OUT), 32'h000);
    check("arst_cnt",   32'(COUNT),    32'd0);
    check("arst_empty", 32'(EMPTY),    32'd1);
    check("arst_zero",  32'(ZERO),     32'd1);
    POP = 1; tick();
    check("arst_hold_err", 32'(ERR), 32'd0);
    REST = 0;
    POP = 1; tick();
    check("post_rst_unf", 32'(ERR), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_reg_unit.md
ADDR_REG_UNIT -- requirements
Module: addr_reg_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data/register width (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, shadow-stack entries (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, register value after reset.
REQ-004 SHALL have one clock, clk; reset is REST, asynchronous, active-high.
REQ-005 SHALL have ports:
- clk  input  1  rising-edge clock
- REST  input  1  async active-high reset
- DATA_IN  input  WIDTH  parallel load data
- CLR, POP, LOAD, INR, DCR, SHL, SHR  input  1 each  operation commands
- SIN  input  1  serial input bit for shifts
- PUSH  input  1  save current register to shadow stack
- DATA_OUT  output  WIDTH  register value Q
- CARRY  output  1  registered carry/borrow/shifted-out bit
- ZERO  output  1  Q == 0
- FULL, EMPTY  output  1 each  stack count == DEPTH / == 0
- COUNT  output  clog2(DEPTH+1)  stack occupancy
- ERR  output  1  sticky stack overflow/underflow flag

Function
REQ-006 SHALL update Q, CARRY, stack and ERR only on rising clk, except on reset.
REQ-007 SHALL resolve Q commands by fixed priority: CLR > POP > LOAD > INR > DCR > SHL > SHR; lower-priority commands in the same cycle ignored entirely.
REQ-008 SHALL hold Q and CARRY when no Q command is asserted.
REQ-009 CLR: Q<=0, CARRY<=0, ERR<=0; stack unchanged.
REQ-010 LOAD: Q<=DATA_IN, CARRY<=0.
REQ-011 INR: Q<=Q+1 mod 2^WIDTH; CARRY<=1 iff Q was all-ones, else 0.
REQ-012 DCR: Q<=Q-1 mod 2^WIDTH; CARRY<=1 iff Q was 0 (borrow), else 0.
REQ-013 SHL: Q<={Q[WIDTH-2:0],SIN}, CARRY<=Q[WIDTH-1].
REQ-014 SHR: Q<={SIN,Q[WIDTH-1:1]}, CARRY<=Q[0].
REQ-015 POP (winning, not empty, no PUSH): Q<=top entry, COUNT-1, CARRY<=0.
REQ-016 PUSH (no winning POP, not full): top<=pre-edge Q, COUNT+1; the concurrently selected Q command still executes.
REQ-017 PUSH with winning POP, not empty: exchange, Q<=top, top<=pre-edge Q, COUNT unchanged, CARRY<=0.
REQ-018 PUSH when full (no winning POP): push dropped, ERR<=1, Q command still executes.
REQ-019 POP when empty (winning, with or without PUSH): Q, CARRY, stack unchanged, ERR<=1; lower-priority commands still ignored.
REQ-020 POP suppressed by CLR SHALL NOT modify the stack; PUSH with CLR pushes pre-edge Q.
REQ-021 ERR SHALL stay 1 until CLR or reset; a CLR coinciding with an error event leaves ERR=0.
REQ-022 ZERO, FULL, EMPTY, DATA_OUT SHALL be combinational functions of registered state, no added latency.
REQ-023 Every operation SHALL have one-cycle latency: result visible on DATA_OUT after the commanding edge.
REQ-024 Stack SHALL be LIFO; entries above COUNT hold don't-care values.

Reset
REQ-025 REST=1 SHALL immediately, without clk, force Q=RESET_VAL, CARRY=0, COUNT=0, ERR=0; stack storage content not reset.
REQ-026 While REST=1 all commands SHALL be ignored; first operation executes on first rising clk after REST falls.
REQ-027 REST asserted mid-sequence SHALL discard pending stack contents (EMPTY=1).

Verification (WIDTH=12, DEPTH=4, RESET_VAL=0)
REQ-028 Reset between edges, Q=0xABC, COUNT=2 -> DATA_OUT=0x000, COUNT=0, EMPTY=1, ZERO=1 before next edge.
REQ-029 LOAD 0xFFF, then INR -> Q=0x000, CARRY=1, ZERO=1; then DCR -> Q=0xFFF, CARRY=1.
REQ-030 LOAD 0x801, SHL SIN=1 -> Q=0x003, CARRY=1; SHR SIN=0 -> Q=0x001, CARRY=1.
REQ-031 Push 0x111,0x222,0x333,0x444 (FULL=1), fifth PUSH -> ERR=1, COUNT=4; four POPs -> Q=0x444,0x333,0x222,0x111, EMPTY=1; extra POP -> Q holds 0x111.
REQ-032 Q=0x555, stack top 0x0AA, PUSH+POP -> Q=0x0AA, top=0x555, COUNT unchanged; CLR+POP+LOAD -> Q=0, stack unchanged, ERR=0.
REQ-033 Q=0x010, PUSH+INR -> Q=0x011, top=0x010, COUNT+1.
